// File: rtl/init_reset_sequencer.sv
// init_reset_sequencer
// Watches the init-monitor status (device init, I/O bank calibration,
// transceiver init), the fabric PLL lock and an external reset request.
// When every enabled prerequisite has held for FILTER_CYCLES, it releases
// NUM_STAGES fabric reset domains in order, spaced STAGE_DELAY cycles
// apart. A prerequisite loss or a software restart re-asserts every domain
// reset and re-runs the sequence.
//
// Ports:
//   CLK                system clock
//   RESETN             synchronous active-low reset
//   EXT_RST_N          external reset request, active low (asynchronous)
//   DEVICE_INIT_DONE   device initialisation complete (asynchronous)
//   BANK_CALIB_STATUS  bank 7/8/9 calibration done, bit0 = bank 7
//   XCVR_INIT_DONE     transceiver initialisation complete (asynchronous)
//   PLL_LOCK           fabric PLL locked (asynchronous)
//   SW_RST_REQ         single-cycle restart pulse, synchronous to CLK
//   RST_N              per-domain reset, active low, bit0 released first
//   SEQ_DONE           all stages released and settled
//   TIMEOUT_ERR        sticky: prerequisites not met within TIMEOUT_CYCLES
//   LOSS_CNT           saturating count of prerequisite losses after release
//   STATE              0 WAIT, 1 FILTER, 2 RELEASE, 3 RUN
module init_reset_sequencer #(
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned STAGE_DELAY    = 16,
  parameter int unsigned FILTER_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned CNT_W          = 16,
  parameter logic [2:0]  BANK_MASK      = 3'b111,
  parameter bit          USE_XCVR       = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  EXT_RST_N,
  input  logic                  DEVICE_INIT_DONE,
  input  logic [2:0]            BANK_CALIB_STATUS,
  input  logic                  XCVR_INIT_DONE,
  input  logic                  PLL_LOCK,
  input  logic                  SW_RST_REQ,
  output logic [NUM_STAGES-1:0] RST_N,
  output logic                  SEQ_DONE,
  output logic                  TIMEOUT_ERR,
  output logic [7:0]            LOSS_CNT,
  output logic [1:0]            STATE
);

  localparam int unsigned SYNC_W = 7;
  localparam int unsigned LOSS_W = 8;

  localparam logic [CNT_W-1:0] FILT_LIM  = CNT_W'(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] STAGE_LIM = CNT_W'(STAGE_DELAY);
  localparam logic [CNT_W-1:0] TOUT_LIM  = CNT_W'(TIMEOUT_CYCLES);
  // A one-cycle filter is already satisfied by the cycle that leaves WAIT.
  localparam bit FAST_FILT = (FILTER_CYCLES <= 1);

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_FILTER  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  // Two-flop synchronisers for all asynchronous status inputs.
  logic [SYNC_W-1:0] raw_c;
  logic [SYNC_W-1:0] meta_q;
  logic [SYNC_W-1:0] sync_q;

  assign raw_c = {EXT_RST_N, DEVICE_INIT_DONE, BANK_CALIB_STATUS,
                  XCVR_INIT_DONE, PLL_LOCK};

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= raw_c;
      sync_q <= meta_q;
    end
  end

  // All enabled prerequisites met this cycle.
  logic       ok_c;
  logic       ext_s;
  logic       dev_s;
  logic [2:0] bank_s;
  logic       xcvr_s;
  logic       pll_s;

  assign ext_s  = sync_q[6];
  assign dev_s  = sync_q[5];
  assign bank_s = sync_q[4:2];
  assign xcvr_s = sync_q[1];
  assign pll_s  = sync_q[0];
  assign ok_c   = ext_s & dev_s & pll_s & (&(bank_s | ~BANK_MASK))
                & (xcvr_s | ~USE_XCVR);

  state_t                  state_q, state_d;
  logic [NUM_STAGES-1:0]   rst_q, rst_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [LOSS_W-1:0]       loss_q, loss_d;
  logic [CNT_W-1:0]        fcnt_q, fcnt_d;
  logic [CNT_W-1:0]        dly_q, dly_d;
  logic [CNT_W-1:0]        tcnt_q, tcnt_d;

  logic [CNT_W-1:0]        fcnt_inc_c;
  logic [CNT_W-1:0]        dly_inc_c;
  logic [CNT_W-1:0]        tcnt_inc_c;
  logic [LOSS_W-1:0]       loss_inc_c;
  logic                    restart_c;
  logic                    lost_c;

  assign fcnt_inc_c = fcnt_q + CNT_W'(1);
  assign dly_inc_c  = dly_q + CNT_W'(1);
  assign tcnt_inc_c = (tcnt_q >= TOUT_LIM) ? tcnt_q : tcnt_q + CNT_W'(1);
  assign loss_inc_c = (&loss_q) ? loss_q : loss_q + LOSS_W'(1);

  // State register and datapath registers.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q <= ST_WAIT;
      rst_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      loss_q  <= '0;
      fcnt_q  <= '0;
      dly_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      err_q   <= err_d;
      loss_q  <= loss_d;
      fcnt_q  <= fcnt_d;
      dly_q   <= dly_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    rst_d     = rst_q;
    done_d    = done_q;
    err_d     = err_q;
    loss_d    = loss_q;
    fcnt_d    = fcnt_q;
    dly_d     = dly_q;
    tcnt_d    = tcnt_q;
    restart_c = 1'b0;
    lost_c    = 1'b0;

    case (state_q)
      ST_WAIT: begin
        rst_d  = '0;
        done_d = 1'b0;
        dly_d  = '0;
        tcnt_d = tcnt_inc_c;
        if (ok_c) begin
          if (FAST_FILT) begin
            state_d = ST_RELEASE;
            rst_d   = NUM_STAGES'(1);
            tcnt_d  = '0;
          end else begin
            state_d = ST_FILTER;
            fcnt_d  = CNT_W'(1);
          end
        end
      end

      ST_FILTER: begin
        tcnt_d = tcnt_inc_c;
        if (SW_RST_REQ) begin
          restart_c = 1'b1;
        end else if (!ok_c) begin
          state_d = ST_WAIT;
          fcnt_d  = '0;
        end else if (fcnt_inc_c >= FILT_LIM) begin
          state_d = ST_RELEASE;
          rst_d   = NUM_STAGES'(1);
          fcnt_d  = '0;
          dly_d   = '0;
          tcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_inc_c;
        end
      end

      ST_RELEASE: begin
        if (!ok_c || SW_RST_REQ) begin
          restart_c = 1'b1;
          lost_c    = !ok_c;
        end else if (dly_inc_c >= STAGE_LIM) begin
          dly_d = '0;
          if (rst_q[NUM_STAGES-1]) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end else begin
            // Release the next domain by shifting a one in from bit0.
            rst_d = NUM_STAGES'({rst_q, 1'b1});
          end
        end else begin
          dly_d = dly_inc_c;
        end
      end

      ST_RUN: begin
        rst_d  = '1;
        done_d = 1'b1;
        if (!ok_c || SW_RST_REQ) begin
          restart_c = 1'b1;
          lost_c    = !ok_c;
        end
      end

      default: begin
        restart_c = 1'b1;
      end
    endcase

    if (restart_c) begin
      state_d = ST_WAIT;
      rst_d   = '0;
      done_d  = 1'b0;
      fcnt_d  = '0;
      dly_d   = '0;
      tcnt_d  = '0;
    end

    // A loss coinciding with a software restart still counts once.
    if (lost_c) begin
      loss_d = loss_inc_c;
    end

    if (tcnt_d >= TOUT_LIM) begin
      err_d = 1'b1;
    end
  end

  assign RST_N       = rst_q;
  assign SEQ_DONE    = done_q;
  assign TIMEOUT_ERR = err_q;
  assign LOSS_CNT    = loss_q;
  assign STATE       = state_q;

endmodule

// File: tb/tb_init_reset_sequencer.sv
// Self-checking bench for init_reset_sequencer. Two instances share every
// input: dut_a enables all three banks, dut_b ignores bank 8.
module tb_init_reset_sequencer;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic       EXT_RST_N;
  logic       DEVICE_INIT_DONE;
  logic [2:0] BANK_CALIB_STATUS;
  logic       XCVR_INIT_DONE;
  logic       PLL_LOCK;
  logic       SW_RST_REQ;

  logic [3:0] rst_a, rst_b;
  logic       done_a, done_b;
  logic       err_a, err_b;
  logic [7:0] loss_a, loss_b;
  logic [1:0] state_a, state_b;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 CLK = ~CLK;

  init_reset_sequencer #(
    .NUM_STAGES(4), .STAGE_DELAY(4), .FILTER_CYCLES(3), .TIMEOUT_CYCLES(20),
    .CNT_W(16), .BANK_MASK(3'b111), .USE_XCVR(1'b1)
  ) dut_a (
    .CLK(CLK), .RESETN(RESETN), .EXT_RST_N(EXT_RST_N),
    .DEVICE_INIT_DONE(DEVICE_INIT_DONE), .BANK_CALIB_STATUS(BANK_CALIB_STATUS),
    .XCVR_INIT_DONE(XCVR_INIT_DONE), .PLL_LOCK(PLL_LOCK), .SW_RST_REQ(SW_RST_REQ),
    .RST_N(rst_a), .SEQ_DONE(done_a), .TIMEOUT_ERR(err_a), .LOSS_CNT(loss_a),
    .STATE(state_a)
  );

  init_reset_sequencer #(
    .NUM_STAGES(4), .STAGE_DELAY(4), .FILTER_CYCLES(3), .TIMEOUT_CYCLES(20),
    .CNT_W(16), .BANK_MASK(3'b101), .USE_XCVR(1'b1)
  ) dut_b (
    .CLK(CLK), .RESETN(RESETN), .EXT_RST_N(EXT_RST_N),
    .DEVICE_INIT_DONE(DEVICE_INIT_DONE), .BANK_CALIB_STATUS(BANK_CALIB_STATUS),
    .XCVR_INIT_DONE(XCVR_INIT_DONE), .PLL_LOCK(PLL_LOCK), .SW_RST_REQ(SW_RST_REQ),
    .RST_N(rst_b), .SEQ_DONE(done_b), .TIMEOUT_ERR(err_b), .LOSS_CNT(loss_b),
    .STATE(state_b)
  );

  // One record: inputs held for ncyc edges, then outputs compared.
  typedef struct {
    logic        rn, ext, dev;
    logic [2:0]  bank;
    logic        xcvr, pll, sw;
    int unsigned ncyc;
    logic [3:0]  rst;
    logic        done;
    logic [1:0]  st;
    logic        err;
    logic [7:0]  loss;
    logic        chk_b;
    logic [3:0]  b_rst;
    logic        b_done;
    logic [1:0]  b_st;
    logic        b_err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(input logic rn, ext, dev, input logic [2:0] bank,
                             input logic xcvr, pll, sw, input int unsigned n,
                             input logic [3:0] r, input logic d,
                             input logic [1:0] s, input logic e,
                             input logic [7:0] l);
    vec_t x;
    x.rn = rn; x.ext = ext; x.dev = dev; x.bank = bank;
    x.xcvr = xcvr; x.pll = pll; x.sw = sw; x.ncyc = n;
    x.rst = r; x.done = d; x.st = s; x.err = e; x.loss = l;
    x.chk_b = 1'b0; x.b_rst = '0; x.b_done = 1'b0; x.b_st = '0; x.b_err = 1'b0;
    return x;
  endfunction

  function automatic vec_t vb(input vec_t base, input logic [3:0] r,
                              input logic d, input logic [1:0] s, input logic e);
    vec_t x = base;
    x.chk_b = 1'b1; x.b_rst = r; x.b_done = d; x.b_st = s; x.b_err = e;
    return x;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %0h, expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Bounded wait for dut_a to reach a state; expiry is a failed comparison.
  task automatic wait_state(input logic [1:0] s, input int unsigned budget,
                            input string name, input int idx);
    int unsigned k = 0;
    while (state_a !== s && k < budget) begin
      tick(1);
      k++;
    end
    check(name, idx, 32'(state_a), 32'(s));
  endtask

  initial begin
    RESETN = 1'b0; EXT_RST_N = 1'b0; DEVICE_INIT_DONE = 1'b0;
    BANK_CALIB_STATUS = 3'b000; XCVR_INIT_DONE = 1'b0; PLL_LOCK = 1'b0;
    SW_RST_REQ = 1'b0;

    // Reset, then nominal bring-up: all prerequisites rise at E0.
    vq.push_back(v(0,0,0,3'b000,0,0,0,  2, 4'h0,0,2'd0,0,8'd0));
    vq.push_back(v(1,1,1,3'b111,1,1,0,  4, 4'h0,0,2'd1,0,8'd0)); // E3
    vq.push_back(v(1,1,1,3'b111,1,1,0,  1, 4'h1,0,2'd2,0,8'd0)); // E4
    vq.push_back(v(1,1,1,3'b111,1,1,0,  3, 4'h1,0,2'd2,0,8'd0)); // E7
    vq.push_back(v(1,1,1,3'b111,1,1,0,  1, 4'h3,0,2'd2,0,8'd0)); // E8
    vq.push_back(v(1,1,1,3'b111,1,1,0,  3, 4'h3,0,2'd2,0,8'd0)); // E11
    vq.push_back(v(1,1,1,3'b111,1,1,0,  1, 4'h7,0,2'd2,0,8'd0)); // E12
    vq.push_back(v(1,1,1,3'b111,1,1,0,  4, 4'hF,0,2'd2,0,8'd0)); // E16
    vq.push_back(v(1,1,1,3'b111,1,1,0,  3, 4'hF,0,2'd2,0,8'd0)); // E19
    vq.push_back(v(1,1,1,3'b111,1,1,0,  1, 4'hF,1,2'd3,0,8'd0)); // E20
    vq.push_back(v(1,1,1,3'b111,1,1,0,  5, 4'hF,1,2'd3,0,8'd0));
    // Loss in RUN: transceiver drops, seen after the synchroniser.
    vq.push_back(v(1,1,1,3'b111,0,1,0,  2, 4'hF,1,2'd3,0,8'd0));
    vq.push_back(v(1,1,1,3'b111,0,1,0,  1, 4'h0,0,2'd0,0,8'd1));
    vq.push_back(v(1,1,1,3'b111,0,1,0,  3, 4'h0,0,2'd0,0,8'd1));
    // Recovery re-runs with the same spacing.
    vq.push_back(v(1,1,1,3'b111,1,1,0,  4, 4'h0,0,2'd1,0,8'd1));
    vq.push_back(v(1,1,1,3'b111,1,1,0,  1, 4'h1,0,2'd2,0,8'd1));
    vq.push_back(v(1,1,1,3'b111,1,1,0,  4, 4'h3,0,2'd2,0,8'd1));
    vq.push_back(v(1,1,1,3'b111,1,1,0, 12, 4'hF,1,2'd3,0,8'd1));
    // Loss and software restart on the same edge count once.
    vq.push_back(v(1,1,1,3'b111,1,0,0,  2, 4'hF,1,2'd3,0,8'd1));
    vq.push_back(v(1,1,1,3'b111,1,0,1,  1, 4'h0,0,2'd0,0,8'd2));
    vq.push_back(v(1,1,1,3'b111,1,1,0,  4, 4'h0,0,2'd1,0,8'd2));
    vq.push_back(v(1,1,1,3'b111,1,1,0,  1, 4'h1,0,2'd2,0,8'd2));
    vq.push_back(v(1,1,1,3'b111,1,1,0,  4, 4'h3,0,2'd2,0,8'd2));
    // Software restart at 0011: no loss counted, restarts immediately.
    vq.push_back(v(1,1,1,3'b111,1,1,1,  1, 4'h0,0,2'd0,0,8'd2));
    vq.push_back(v(1,1,1,3'b111,1,1,0,  3, 4'h1,0,2'd2,0,8'd2));
    // RESETN mid-RELEASE.
    vq.push_back(v(0,1,1,3'b111,1,1,0,  1, 4'h0,0,2'd0,0,8'd0));
    // Filter glitch on PLL_LOCK: 1,1,0,1,1...
    vq.push_back(v(1,1,1,3'b111,1,1,0,  1, 4'h0,0,2'd0,0,8'd0)); // P0
    vq.push_back(v(1,1,1,3'b111,1,1,0,  1, 4'h0,0,2'd0,0,8'd0)); // P1
    vq.push_back(v(1,1,1,3'b111,1,0,0,  1, 4'h0,0,2'd1,0,8'd0)); // P2
    vq.push_back(v(1,1,1,3'b111,1,1,0,  1, 4'h0,0,2'd1,0,8'd0)); // P3
    vq.push_back(v(1,1,1,3'b111,1,1,0,  1, 4'h0,0,2'd0,0,8'd0)); // P4
    vq.push_back(v(1,1,1,3'b111,1,1,0,  1, 4'h0,0,2'd1,0,8'd0)); // P5
    vq.push_back(v(1,1,1,3'b111,1,1,0,  1, 4'h0,0,2'd1,0,8'd0)); // P6
    vq.push_back(v(1,1,1,3'b111,1,1,0,  1, 4'h1,0,2'd2,0,8'd0)); // P7
    vq.push_back(v(0,0,0,3'b000,0,0,0,  2, 4'h0,0,2'd0,0,8'd0));
    // Bank 8 low: dut_a times out, dut_b (bank 8 masked) runs nominally.
    vq.push_back(vb(v(1,1,1,3'b101,1,1,0,  4, 4'h0,0,2'd0,0,8'd0), 4'h0,0,2'd1,0));
    vq.push_back(vb(v(1,1,1,3'b101,1,1,0,  1, 4'h0,0,2'd0,0,8'd0), 4'h1,0,2'd2,0));
    vq.push_back(vb(v(1,1,1,3'b101,1,1,0, 14, 4'h0,0,2'd0,0,8'd0), 4'hF,0,2'd2,0));
    vq.push_back(vb(v(1,1,1,3'b101,1,1,0,  1, 4'h0,0,2'd0,1,8'd0), 4'hF,0,2'd2,0));
    vq.push_back(vb(v(1,1,1,3'b101,1,1,0,  1, 4'h0,0,2'd0,1,8'd0), 4'hF,1,2'd3,0));
    vq.push_back(vb(v(1,1,1,3'b101,1,1,0,  9, 4'h0,0,2'd0,1,8'd0), 4'hF,1,2'd3,0));
    // Bank 8 recovers: dut_a sequences, error stays sticky.
    vq.push_back(vb(v(1,1,1,3'b111,1,1,0,  4, 4'h0,0,2'd1,1,8'd0), 4'hF,1,2'd3,0));
    vq.push_back(v(1,1,1,3'b111,1,1,0,  1, 4'h1,0,2'd2,1,8'd0));
    vq.push_back(v(1,1,1,3'b111,1,1,0, 16, 4'hF,1,2'd3,1,8'd0));

    for (int i = 0; i < vq.size(); i++) begin
      RESETN = vq[i].rn; EXT_RST_N = vq[i].ext; DEVICE_INIT_DONE = vq[i].dev;
      BANK_CALIB_STATUS = vq[i].bank; XCVR_INIT_DONE = vq[i].xcvr;
      PLL_LOCK = vq[i].pll; SW_RST_REQ = vq[i].sw;
      tick(vq[i].ncyc);
      check("rst_n",    i, 32'(rst_a),   32'(vq[i].rst));
      check("seq_done", i, 32'(done_a),  32'(vq[i].done));
      check("state",    i, 32'(state_a), 32'(vq[i].st));
      check("timeout",  i, 32'(err_a),   32'(vq[i].err));
      check("loss_cnt", i, 32'(loss_a),  32'(vq[i].loss));
      if (vq[i].chk_b) begin
        check("mask_rst_n",    i, 32'(rst_b),   32'(vq[i].b_rst));
        check("mask_seq_done", i, 32'(done_b),  32'(vq[i].b_done));
        check("mask_state",    i, 32'(state_b), 32'(vq[i].b_st));
        check("mask_timeout",  i, 32'(err_b),   32'(vq[i].b_err));
      end
    end

    // Repeated losses during RELEASE: LOSS_CNT saturates at 255.
    for (int i = 0; i < 260; i++) begin
      if (i[0]) EXT_RST_N = 1'b0;
      else      PLL_LOCK  = 1'b0;
      wait_state(2'd0, 8, "loss_to_wait", i);
      check("sat_loss_cnt", i, 32'(loss_a), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
      check("sat_rst_n",    i, 32'(rst_a),  32'd0);
      EXT_RST_N = 1'b1;
      PLL_LOCK  = 1'b1;
      wait_state(2'd2, 10, "reach_release", i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
